// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver.
//
// Oversamples the asynchronous serial line with a baud counter and recovers
// one byte per frame (start bit, 8 data bits LSB first, one stop bit).
// Good bytes are delivered as a one-cycle o_rx_valid pulse with o_rx_data;
// a low stop bit produces a one-cycle o_frame_err pulse instead.
//
// Ports:
//   i_clk        system clock, all logic on the rising edge
//   i_rst        synchronous reset, active-high
//   i_rx         asynchronous serial line, idle high
//   o_rx_valid   one-cycle pulse: o_rx_data holds a newly received byte
//   o_rx_data    last good byte, held until the next good byte
//   o_frame_err  one-cycle pulse: stop bit sampled low
//   o_busy       high whenever the receiver is not idle
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_data,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LAST_HALF = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_idx, w_idx_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_rx_m, r_rx_s;
    logic          r_valid, w_valid_nxt;
    logic          r_ferr, w_ferr_nxt;
    logic [7:0]    r_data, w_data_nxt;

    // Two-flop synchronizer, preset to the idle (high) line level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_m <= 1'b1;
            r_rx_s <= 1'b1;
        end else begin
            r_rx_m <= i_rx;
            r_rx_s <= r_rx_m;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
            r_data  <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        w_data_nxt  = r_data;

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (!r_rx_s) w_state_nxt = START;
            end
            START: begin
                if (r_cnt == LAST_HALF) begin
                    // A line that is high again at mid-start was a glitch.
                    w_state_nxt = r_rx_s ? IDLE : DATA;
                    w_idx_nxt   = '0;
                end
            end
            DATA: begin
                if (r_cnt == LAST_BIT) begin
                    w_shift_nxt = {r_rx_s, r_shift[7:1]};
                    if (r_idx == 3'd7) w_state_nxt = STOP;
                    else               w_idx_nxt   = r_idx + 1'b1;
                end
            end
            STOP: begin
                if (r_cnt == LAST_BIT) begin
                    if (r_rx_s) begin
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = r_shift;
                        // Returning at mid-stop lets a back-to-back start edge be caught.
                        w_state_nxt = IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (r_rx_s) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        // The baud counter restarts on every state change.
        if (w_state_nxt != r_state) w_cnt_nxt = '0;
    end

    assign o_rx_valid  = r_valid;
    assign o_rx_data   = r_data;
    assign o_frame_err = r_ferr;
    assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       frame_err;
    logic       busy;

    int ncmp  = 0;
    int nfail = 0;

    int cyc = 0;
    int vcnt = 0;
    int fcnt = 0;
    int both_cnt = 0;
    int busy_cnt = 0;
    int valid_cyc = 0;
    int busy_last_hi = 0;
    logic [7:0] hist [0:63];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rx       (rx),
        .o_rx_valid (rx_valid),
        .o_rx_data  (rx_data),
        .o_frame_err(frame_err),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs half a cycle away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            hist[vcnt[5:0]] = rx_data;
            vcnt = vcnt + 1;
            valid_cyc = cyc;
        end
        if (frame_err) fcnt = fcnt + 1;
        if (rx_valid && frame_err) both_cnt = both_cnt + 1;
        if (busy) begin
            busy_cnt = busy_cnt + 1;
            busy_last_hi = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopv);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stopv;
        tick(CPB);
    endtask

    int v0, f0, b0, t0, lat;

    initial begin
        // Reset then idle
        rst = 1'b1; rx = 1'b1;
        tick(3);
        @(negedge clk);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_data", {24'd0, rx_data}, 32'h00);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        b0 = busy_cnt;
        tick(200);
        check("idle_busy", busy_cnt - b0, 0);

        // Single byte with latency check
        v0 = vcnt; f0 = fcnt;
        t0 = cyc;
        send_frame(8'h35, 1'b1);
        tick(20);
        lat = valid_cyc - t0;
        check("single_cnt", vcnt - v0, 1);
        check("single_data", {24'd0, hist[v0[5:0]]}, 32'h35);
        check("single_lat", (lat >= 154 && lat <= 156) ? 1 : 0, 1);
        check("single_busyfall", busy_last_hi, valid_cyc - 1);
        check("single_busy_end", {31'd0, busy}, 32'd0);
        check("single_ferr", fcnt - f0, 0);

        // Back-to-back frames
        v0 = vcnt; f0 = fcnt;
        send_frame(8'h31, 1'b1);
        send_frame(8'h61, 1'b1);
        send_frame(8'h39, 1'b1);
        tick(20);
        check("b2b_cnt", vcnt - v0, 3);
        check("b2b_d0", {24'd0, hist[v0[5:0]]}, 32'h31);
        check("b2b_d1", {24'd0, hist[v0[5:0] + 6'd1]}, 32'h61);
        check("b2b_d2", {24'd0, hist[v0[5:0] + 6'd2]}, 32'h39);
        check("b2b_ferr", fcnt - f0, 0);

        // Glitch rejection
        v0 = vcnt; f0 = fcnt;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(40);
        check("glitch_valid", vcnt - v0, 0);
        check("glitch_ferr", fcnt - f0, 0);
        check("glitch_data", {24'd0, rx_data}, 32'h39);
        check("glitch_busy", {31'd0, busy}, 32'd0);

        // Framing error, then recovery
        v0 = vcnt; f0 = fcnt;
        send_frame(8'hA5, 1'b0);
        tick(40);
        check("ferr_busy_low", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        tick(40);
        check("ferr_cnt", fcnt - f0, 1);
        check("ferr_valid", vcnt - v0, 0);
        check("ferr_data", {24'd0, rx_data}, 32'h39);
        v0 = vcnt;
        send_frame(8'h30, 1'b1);
        tick(20);
        check("ferr_next_cnt", vcnt - v0, 1);
        check("ferr_next_data", {24'd0, rx_data}, 32'h30);

        // Reset mid-frame during data bit 3 of 0x7E
        v0 = vcnt; f0 = fcnt;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = (8'h7E >> i) & 8'h1;
            tick(CPB);
        end
        rx = 1'b1;  // bit 3 of 0x7E
        tick(CPB / 2);
        check("mid_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick(2);
        @(negedge clk);
        check("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
        check("mid_rst_data", {24'd0, rx_data}, 32'h00);
        check("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rx  = 1'b1;
        tick(40);
        check("mid_no_valid", vcnt - v0, 0);
        check("mid_no_ferr", fcnt - f0, 0);
        send_frame(8'h32, 1'b1);
        tick(20);
        check("mid_next_cnt", vcnt - v0, 1);
        check("mid_next_data", {24'd0, rx_data}, 32'h32);

        check("never_both", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
